pixel_write_buffer: RTL and testbench
=====================================

PIXEL_WRITE_BUFFER -- requirements
Module: pixel_write_buffer

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; power of two, minimum 2.
REQ-002 Parameter H_RES, default 640, visible width in pixels.
REQ-003 Parameter V_RES, default 480, visible height in pixels.
REQ-004 Parameter COLOR_W, default 8, pixel colour width.
REQ-005 Port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1 bit, asynchronous and active-low.
REQ-007 Port px_valid, input, 1 bit, upstream rasterizer presents a pixel.
REQ-008 Port px_x, input, 10 bits, pixel column (unsigned).
REQ-009 Port px_y, input, 9 bits, pixel row (unsigned).
REQ-010 Port px_color, input, COLOR_W bits, pixel colour.
REQ-011 Port px_ready, output, 1 bit, block accepts a pixel this cycle.
REQ-012 Port prim_finish, input, 1 bit, level from the rasterizer: primitive complete.
REQ-013 Port mem_we, output, 1 bit, framebuffer write request.
REQ-014 Port mem_addr, output, 19 bits, linear framebuffer address.
REQ-015 Port mem_data, output, COLOR_W bits, write data.
REQ-016 Port mem_ready, input, 1 bit, framebuffer accepts the write this cycle.
REQ-017 Port done, output, 1 bit, one-cycle pulse: primitive fully written.
REQ-018 Port drop_cnt, output, 16 bits, count of clipped or duplicate pixels.

Function
REQ-019 The input handshake SHALL complete on a rising edge where px_valid and px_ready are both 1; px_ready = NOT fifo_full, registered, with no same-cycle pop bypass.
REQ-020 On an accepted pixel with px_x >= H_RES or px_y >= V_RES, the block SHALL consume it, push nothing, and increment drop_cnt.
REQ-021 On an accepted pixel whose (px_x, px_y) equals the previously accepted in-range pixel since the last done/reset, the block SHALL consume it, push nothing, and increment drop_cnt.
REQ-022 drop_cnt SHALL saturate at 16'hFFFF and clear only on reset.
REQ-023 Pushed entries SHALL hold {addr, color} with addr = px_y*H_RES + px_x, computed combinationally before the push (shift-add allowed for 640: (y<<9)+(y<<7)+x), 19-bit, no truncation.
REQ-024 FIFO SHALL be circular with DEPTH entries; read/write pointers wrap modulo DEPTH; full/empty from a log2(DEPTH)+1-bit occupancy count.
REQ-025 Simultaneous push and pop SHALL leave the count unchanged; a push while full is impossible because px_ready=0.
REQ-026 The output stage SHALL be a holding register: when empty or popped, it loads the FIFO head and asserts mem_we the next cycle.
REQ-027 While mem_we=1 and mem_ready=0, mem_addr and mem_data SHALL stay stable; on mem_we=1 and mem_ready=1 the write retires and the next entry, if any, appears the following cycle (throughput one write per cycle while mem_ready stays 1).
REQ-028 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-029 IDLE -> RUN when px_valid=1; IDLE -> DRAIN when prim_finish=1 with no pixel pending.
REQ-030 RUN -> DRAIN when prim_finish=1; pixels presented in the same cycle are still accepted.
REQ-031 In DRAIN, px_ready SHALL be 0; DRAIN -> DONE when the FIFO is empty and no write is outstanding.
REQ-032 In DONE, done=1 for exactly one cycle, the duplicate-compare register is invalidated, and the FSM returns to IDLE; prim_finish must drop before it is sampled again in IDLE (edge-qualified: IDLE ignores prim_finish until it has been observed 0).
REQ-033 Pixel order at the memory port SHALL equal acceptance order minus dropped pixels.

Reset
REQ-034 reset=0 SHALL immediately clear pointers, count, holding register, and duplicate register and force IDLE, regardless of clock.
REQ-035 During and after reset until the first pixel: px_ready=1, mem_we=0, mem_addr=0, mem_data=0, done=0, drop_cnt=0.
REQ-036 A reset asserted mid-write SHALL abandon the outstanding write and all queued entries; no write occurs after release until new pixels are accepted.

Verification
REQ-037 Pixel (10,20,color 5A), mem_ready=1 -> mem_we=1, mem_addr=12810, mem_data=5A within 2 cycles of acceptance.
REQ-038 Pixels (639,479), (640,0), (0,480) -> one write at addr 307199; drop_cnt=2.
REQ-039 Pixel (7,3) presented three consecutive times -> a single write at addr 1927; drop_cnt=2.
REQ-040 mem_ready=0 held while 9 distinct pixels are offered (DEPTH=8) -> px_ready=0 after 8 in FIFO plus 1 in holding; mem_addr stable; releasing mem_ready yields 9 writes in order, one per cycle.
REQ-041 prim_finish raised with 3 queued pixels -> px_ready=0, 3 writes, then done pulses exactly one cycle, FSM in IDLE.
REQ-042 reset pulsed low mid-burst with mem_ready=0 -> mem_we=0 immediately, no further writes, drop_cnt=0.

Source files
------------

// File: rtl/pixel_write_buffer_if.sv
// pixel_write_buffer_if: rasterizer-side pixel handshake and framebuffer write port bundle
interface pixel_write_buffer_if #(parameter int COLOR_W = 8);
   logic               px_valid;
   logic [9:0]         px_x;
   logic [8:0]         px_y;
   logic [COLOR_W-1:0] px_color;
   logic               px_ready;
   logic               prim_finish;
   logic               mem_we;
   logic [18:0]        mem_addr;
   logic [COLOR_W-1:0] mem_data;
   logic               mem_ready;
   logic               done;
   logic [15:0]        drop_cnt;
   modport master (
      output px_valid, px_x, px_y, px_color, prim_finish, mem_ready,
      input  px_ready, mem_we, mem_addr, mem_data, done, drop_cnt
   );
   modport slave (
      input  px_valid, px_x, px_y, px_color, prim_finish, mem_ready,
      output px_ready, mem_we, mem_addr, mem_data, done, drop_cnt
   );
endinterface

// File: rtl/pixel_write_buffer.sv
// pixel_write_buffer: clips and de-duplicates rasterized pixels, queues them and
// streams linear-address writes to the framebuffer, pulsing done per primitive.
module pixel_write_buffer #(
   parameter int DEPTH   = 8,
   parameter int H_RES   = 640,
   parameter int V_RES   = 480,
   parameter int COLOR_W = 8
) (
   input logic clk,
   input logic reset,
   pixel_write_buffer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t state, state_n;
   logic [AW-1:0] wp, rp;
   logic [CW-1:0] count, count_n;
   logic [18+COLOR_W:0] fifo [DEPTH];
   logic [18:0] addr;
   logic acc, oor, dup, push, pop, fin, armed, dup_v;
   logic [9:0] dup_x;
   logic [8:0] dup_y;
   // prim_finish only counts once it has been seen low since the last done
   assign fin     = bus.prim_finish && armed;
   assign acc     = bus.px_valid && bus.px_ready;
   assign oor     = int'(bus.px_x) >= H_RES || int'(bus.px_y) >= V_RES;
   assign dup     = dup_v && bus.px_x == dup_x && bus.px_y == dup_y;
   assign push    = acc && !oor && !dup;
   assign pop     = count != '0 && (!bus.mem_we || bus.mem_ready);
   assign count_n = count + CW'(push) - CW'(pop);
   assign addr    = 19'(bus.px_y) * 19'(H_RES) + 19'(bus.px_x);
   assign bus.done = state == DONE;
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:  state_n = bus.px_valid ? RUN : fin ? DRAIN : IDLE;
         RUN:   state_n = fin ? DRAIN : RUN;
         DRAIN: state_n = (count == '0 && !bus.mem_we) ? DONE : DRAIN;
         DONE:  state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) if (push) fifo[wp] <= {addr, bus.px_color};
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         wp           <= '0;
         rp           <= '0;
         count        <= '0;
         armed        <= 1'b0;
         dup_v        <= 1'b0;
         dup_x        <= '0;
         dup_y        <= '0;
         bus.px_ready <= 1'b1;
         bus.mem_we   <= 1'b0;
         bus.mem_addr <= '0;
         bus.mem_data <= '0;
         bus.drop_cnt <= '0;
      end else begin
         state        <= state_n;
         count        <= count_n;
         armed        <= !bus.prim_finish || (armed && state != DONE);
         bus.px_ready <= count_n != CW'(DEPTH) && (state_n == IDLE || state_n == RUN);
         bus.mem_we   <= pop || (bus.mem_we && !bus.mem_ready);
         if (push) wp <= wp + AW'(1);
         if (pop) begin
            rp <= rp + AW'(1);
            {bus.mem_addr, bus.mem_data} <= fifo[rp];
         end
         if (state == DONE) dup_v <= 1'b0;
         else if (acc && !oor) {dup_v, dup_x, dup_y} <= {1'b1, bus.px_x, bus.px_y};
         if (acc && (oor || dup) && bus.drop_cnt != '1) bus.drop_cnt <= bus.drop_cnt + 16'd1;
      end
   end
endmodule

// File: tb/tb_pixel_write_buffer.sv
// tb_pixel_write_buffer: directed checks of clipping, de-dup, backpressure,
// primitive completion and mid-burst reset.
module tb_pixel_write_buffer;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int checks = 0, errors = 0, cyc = 0, d;
   logic [18:0] wa[$];
   logic [7:0]  wd[$];
   int          wc[$];
   pixel_write_buffer_if #(.COLOR_W(8)) bus();
   pixel_write_buffer dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   // a write retires on the coming rising edge
   always @(negedge clk)
      if (reset && bus.mem_we && bus.mem_ready) begin
         wa.push_back(bus.mem_addr);
         wd.push_back(bus.mem_data);
         wc.push_back(cyc);
      end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #2;
   endtask
   task automatic run(input int n);
      repeat (n) tick();
   endtask
   task automatic clear_log();
      wa.delete();
      wd.delete();
      wc.delete();
   endtask
   task automatic send(input int x, input int y, input int c);
      logic a;
      a = 1'b0;
      bus.px_valid = 1'b1;
      bus.px_x = 10'(x);
      bus.px_y = 9'(y);
      bus.px_color = 8'(c);
      for (int i = 0; i < 40 && !a; i++) begin
         a = bus.px_ready;
         tick();
      end
      bus.px_valid = 1'b0;
      chk("send_accepted", 32'(a), 1);
   endtask
   initial begin
      bus.px_valid = 0; bus.px_x = 0; bus.px_y = 0; bus.px_color = 0;
      bus.prim_finish = 0; bus.mem_ready = 1;
      run(3);
      chk("rst_px_ready", 32'(bus.px_ready), 1);
      chk("rst_mem_we", 32'(bus.mem_we), 0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 0);
      chk("rst_mem_data", 32'(bus.mem_data), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_drop", 32'(bus.drop_cnt), 0);
      reset = 1'b1;
      tick();
      send(10, 20, 'h5A);
      tick();
      chk("t1_mem_we", 32'(bus.mem_we), 1);
      chk("t1_addr", 32'(bus.mem_addr), 12810);
      chk("t1_data", 32'(bus.mem_data), 'h5A);
      tick();
      chk("t1_writes", wa.size(), 1);
      chk("t1_we_low", 32'(bus.mem_we), 0);
      clear_log();
      send(639, 479, 1);
      send(640, 0, 2);
      send(0, 480, 3);
      run(5);
      chk("t2_writes", wa.size(), 1);
      chk("t2_addr", 32'(wa[0]), 307199);
      chk("t2_drop", 32'(bus.drop_cnt), 2);
      clear_log();
      repeat (3) send(7, 3, 9);
      run(5);
      chk("t3_writes", wa.size(), 1);
      chk("t3_addr", 32'(wa[0]), 1927);
      chk("t3_drop", 32'(bus.drop_cnt), 4);
      clear_log();
      bus.mem_ready = 0;
      for (int i = 0; i < 9; i++) send(100 + i, 1, i);
      chk("t4_full_ready", 32'(bus.px_ready), 0);
      chk("t4_mem_we", 32'(bus.mem_we), 1);
      run(3);
      chk("t4_stable_addr", 32'(bus.mem_addr), 740);
      chk("t4_stable_data", 32'(bus.mem_data), 0);
      chk("t4_still_full", 32'(bus.px_ready), 0);
      chk("t4_no_writes", wa.size(), 0);
      bus.mem_ready = 1;
      run(12);
      chk("t4_writes", wa.size(), 9);
      for (int i = 0; i < 9; i++) begin
         chk("t4_order_addr", 32'(wa[i]), 32'(740 + i));
         chk("t4_order_data", 32'(wd[i]), 32'(i));
      end
      chk("t4_one_per_cycle", 32'(wc[8] - wc[0]), 8);
      clear_log();
      bus.mem_ready = 0;
      for (int i = 0; i < 3; i++) send(200 + i, 2, 20 + i);
      bus.prim_finish = 1;
      tick();
      chk("t5_drain_ready", 32'(bus.px_ready), 0);
      chk("t5_no_done_yet", 32'(bus.done), 0);
      bus.mem_ready = 1;
      d = 0;
      for (int i = 0; i < 20; i++) begin
         d += int'(bus.done);
         tick();
      end
      chk("t5_done_pulses", 32'(d), 1);
      chk("t5_writes", wa.size(), 3);
      chk("t5_first_addr", 32'(wa[0]), 1480);
      chk("t5_last_addr", 32'(wa[2]), 1482);
      chk("t5_idle_ready", 32'(bus.px_ready), 1);
      bus.prim_finish = 0;
      tick();
      send(202, 2, 7);
      run(4);
      chk("t5_dup_cleared", wa.size(), 4);
      chk("t5_repeat_addr", 32'(wa[3]), 1482);
      chk("t5_drop", 32'(bus.drop_cnt), 4);
      clear_log();
      bus.mem_ready = 0;
      for (int i = 0; i < 3; i++) send(300 + i, 4, i);
      chk("t6_we_before", 32'(bus.mem_we), 1);
      reset = 1'b0;
      #1;
      chk("t6_we_async", 32'(bus.mem_we), 0);
      chk("t6_addr_async", 32'(bus.mem_addr), 0);
      chk("t6_drop_async", 32'(bus.drop_cnt), 0);
      chk("t6_ready_async", 32'(bus.px_ready), 1);
      run(2);
      reset = 1'b1;
      bus.mem_ready = 1;
      run(10);
      chk("t6_no_writes", wa.size(), 0);
      chk("t6_we_idle", 32'(bus.mem_we), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
